// File: rtl/booth_issue_ctrl_if.sv
// Operand, multiplier and result signals of the Booth issue controller in one bundle.
// The master modport is the surrounding system; the slave modport is the controller.
interface booth_issue_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_mpd;
    logic [WIDTH-1:0]     in_mpr;
    logic                 mul_enable;
    logic [WIDTH-1:0]     mul_mpd;
    logic [WIDTH-1:0]     mul_mpr;
    logic [2*WIDTH-1:0]   mul_res;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_res;

    modport master (
        output in_valid, in_mpd, in_mpr, out_ready, mul_res,
        input  in_ready, mul_enable, mul_mpd, mul_mpr, out_valid, out_res
    );

    modport slave (
        input  in_valid, in_mpd, in_mpr, out_ready, mul_res,
        output in_ready, mul_enable, mul_mpd, mul_mpr, out_valid, out_res
    );
endinterface

// File: rtl/booth_issue_ctrl.sv
// Buffers operand pairs, drives the radix-2 Booth multiplier with an exactly-timed
// enable pulse and hands the captured signed product downstream.
module booth_issue_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    booth_issue_ctrl_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(2 * WIDTH + 2);
    localparam logic [NW-1:0] CCNT_LAST = NW'(2 * WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] CAPT  = 2'd2;

    logic [WIDTH-1:0]   mpdMem_q [DEPTH];
    logic [WIDTH-1:0]   mprMem_q [DEPTH];
    logic [PW-1:0]      wrPtr_q, rdPtr_q;
    logic [CW-1:0]      count_q;

    logic [1:0]         state_q, state_d;
    logic [NW-1:0]      ccnt_q, ccnt_d;
    logic               mulEnable_q, mulEnable_d;
    logic [WIDTH-1:0]   mulMpd_q, mulMpd_d;
    logic [WIDTH-1:0]   mulMpr_q, mulMpr_d;
    logic               outValid_q, outValid_d;
    logic [2*WIDTH-1:0] outRes_q, outRes_d;

    logic push, pop;

    assign bus.in_ready   = (count_q != CW'(DEPTH));
    assign push           = bus.in_valid && bus.in_ready;
    // A pending product blocks issue, which also keeps a handshake cycle from issuing.
    assign pop            = (state_q == IDLE) && (count_q != '0) && !outValid_q;

    assign bus.mul_enable = mulEnable_q;
    assign bus.mul_mpd    = mulMpd_q;
    assign bus.mul_mpr    = mulMpr_q;
    assign bus.out_valid  = outValid_q;
    assign bus.out_res    = outRes_q;
    assign fifo_count     = count_q;
    assign busy           = (state_q == ISSUE) || (state_q == CAPT);

    always_ff @(posedge clock) begin
        if (push) begin
            mpdMem_q[wrPtr_q] <= bus.in_mpd;
            mprMem_q[wrPtr_q] <= bus.in_mpr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Enable stays high for 2*WIDTH+2 multiplier edges: START, the RUN/SHIFT pairs and RESULT.
    always_comb begin
        state_d     = state_q;
        ccnt_d      = ccnt_q;
        mulEnable_d = mulEnable_q;
        mulMpd_d    = mulMpd_q;
        mulMpr_d    = mulMpr_q;
        outValid_d  = outValid_q;
        outRes_d    = outRes_q;

        if (outValid_q && bus.out_ready) outValid_d = 1'b0;

        case (state_q)
            IDLE: begin
                mulEnable_d = 1'b0;
                if (pop) begin
                    mulMpd_d    = mpdMem_q[rdPtr_q];
                    mulMpr_d    = mprMem_q[rdPtr_q];
                    mulEnable_d = 1'b1;
                    ccnt_d      = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                ccnt_d = ccnt_q + NW'(1);
                if (ccnt_q == CCNT_LAST) begin
                    mulEnable_d = 1'b0;
                    state_d     = CAPT;
                end
            end
            CAPT: begin
                outRes_d   = bus.mul_res;
                outValid_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                mulEnable_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ccnt_q      <= '0;
            mulEnable_q <= 1'b0;
            mulMpd_q    <= '0;
            mulMpr_q    <= '0;
            outValid_q  <= 1'b0;
            outRes_q    <= '0;
        end else begin
            state_q     <= state_d;
            ccnt_q      <= ccnt_d;
            mulEnable_q <= mulEnable_d;
            mulMpd_q    <= mulMpd_d;
            mulMpr_q    <= mulMpr_d;
            outValid_q  <= outValid_d;
            outRes_q    <= outRes_d;
        end
    end
endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Bench for booth_issue_ctrl: a Booth multiplier stand-in, a queue-based transaction
// model compared every cycle, and directed scenarios with hand-computed products.
module tb_booth_issue_ctrl;
    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int RW    = 2 * W;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic [CW-1:0] fifo_count;
    logic          busy;

    int checks = 0;
    int errors = 0;

    booth_issue_ctrl_if #(.WIDTH(W)) bus();

    booth_issue_ctrl #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [RW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        int pa;
        int pb;
        pa = int'($signed(a));
        pb = int'($signed(b));
        return RW'(pa * pb);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Multiplier stand-in: the product appears on the 2*W+2-th consecutive enabled edge.
    logic [RW-1:0] mulRes = '0;
    int mulSteps = 0;
    assign bus.mul_res = mulRes;
    always @(posedge clock) begin
        if (bus.mul_enable === 1'b1) begin
            if (mulSteps == 2 * W + 1) mulRes <= prod(bus.mul_mpd, bus.mul_mpr);
            mulSteps <= mulSteps + 1;
        end else begin
            mulSteps <= 0;
        end
    end

    // Transaction model: pending pairs, the pair in flight and cycles since its issue.
    logic [W-1:0]  qMpd[$];
    logic [W-1:0]  qMpr[$];
    logic [W-1:0]  curMpd = '0, curMpr = '0;
    logic [RW-1:0] mRes = '0;
    bit  inflight = 0;
    bit  mValid = 0;
    bit  doPush, doHs;
    int  since = 0;

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            qMpd.delete();
            qMpr.delete();
            curMpd = '0; curMpr = '0; mRes = '0;
            inflight = 0; mValid = 0; since = 0;
        end else begin
            doPush = bus.in_valid && (qMpd.size() < DEPTH);
            doHs   = mValid && bus.out_ready;
            if (inflight) begin
                since++;
                if (since == 2 * W + 3) begin
                    inflight = 0;
                    mValid   = 1;
                    mRes     = prod(curMpd, curMpr);
                end
            end else if (qMpd.size() != 0 && !mValid) begin
                curMpd   = qMpd.pop_front();
                curMpr   = qMpr.pop_front();
                inflight = 1;
                since    = 0;
            end
            if (doHs) mValid = 0;
            if (doPush) begin
                qMpd.push_back(bus.in_mpd);
                qMpr.push_back(bus.in_mpr);
            end
        end
    end

    initial forever begin
        @(negedge clock);
        checkOutput("mul_enable", 32'(bus.mul_enable), 32'(inflight && since < 2 * W + 2));
        checkOutput("mul_operands", 32'({bus.mul_mpd, bus.mul_mpr}), 32'({curMpd, curMpr}));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(mValid));
        checkOutput("out_res", 32'(bus.out_res), 32'(mRes));
        checkOutput("fifo_count", 32'(fifo_count), 32'(qMpd.size()));
        checkOutput("in_ready", 32'(bus.in_ready), 32'(qMpd.size() < DEPTH));
        checkOutput("busy", 32'(busy), 32'(inflight));
    end

    // Event log used by the directed scenarios.
    int cyc = 0;
    int lastIssueCyc = -1000, validRiseCyc = -1000, lastPulseLen = 0;
    int pulseRun = 0, lowRun = 0;
    bit prevEn = 0, prevValid = 0;
    int issueLog[$];
    int gapLog[$];
    logic [RW-1:0] prodLog[$];

    always @(posedge clock) cyc <= cyc + 1;

    initial forever begin
        @(negedge clock);
        if (bus.mul_enable && !prevEn) begin
            lastIssueCyc = cyc;
            issueLog.push_back(cyc);
            gapLog.push_back(lowRun);
            pulseRun = 0;
        end
        if (!bus.mul_enable && prevEn) begin
            lastPulseLen = pulseRun;
            lowRun = 0;
        end
        if (bus.mul_enable) pulseRun++;
        else                lowRun++;
        if (bus.out_valid && !prevValid) validRiseCyc = cyc;
        if (bus.out_valid && bus.out_ready) prodLog.push_back(bus.out_res);
        prevEn    = bus.mul_enable;
        prevValid = bus.out_valid;
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        bus.in_mpd   = a;
        bus.in_mpr   = b;
        bus.in_valid = 1'b1;
        @(negedge clock);
        while (!bus.in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput("push_accepted", 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitValid(input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.out_valid && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput("wait_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic waitProducts(input int count, input int budget);
        int n;
        n = 0;
        while (prodLog.size() < count && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput("product_count", 32'(prodLog.size()), 32'(count));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [RW-1:0] expQ[$];
        logic [RW-1:0] heldRes;
        logic [W-1:0]  ra, rb;
        int n;

        bus.in_valid  = 1'b0;
        bus.in_mpd    = '0;
        bus.in_mpr    = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clock);
        #2;
        checkOutput("reset_mul_enable", 32'(bus.mul_enable), 32'd0);
        checkOutput("reset_mul_operands", 32'({bus.mul_mpd, bus.mul_mpr}), 32'd0);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_res", 32'(bus.out_res), 32'd0);
        checkOutput("reset_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        reset_n = 1'b1;

        $display("[TB] single operation");
        bus.out_ready = 1'b1;
        applyStimulus(4'sd3, 4'sd5);
        waitValid(40);
        checkOutput("single_res", 32'(bus.out_res), 32'h0F);
        checkOutput("single_pulse_len", 32'(lastPulseLen), 32'd10);
        checkOutput("single_latency", 32'(validRiseCyc - lastIssueCyc), 32'd11);
        @(posedge clock);
        #2;

        $display("[TB] signed sequence");
        issueLog.delete();
        gapLog.delete();
        prodLog.delete();
        applyStimulus(-4'sd3, 4'sd5);
        applyStimulus(4'sd7, -4'sd2);
        applyStimulus(-4'sd4, -4'sd4);
        waitProducts(3, 200);
        if (prodLog.size() == 3) begin
            checkOutput("signed_res0", 32'(prodLog[0]), 32'hF1);
            checkOutput("signed_res1", 32'(prodLog[1]), 32'hF2);
            checkOutput("signed_res2", 32'(prodLog[2]), 32'h10);
        end
        checkOutput("signed_issue_count", 32'(issueLog.size()), 32'd3);
        if (issueLog.size() == 3) begin
            checkOutput("issue_spacing01", 32'(issueLog[1] - issueLog[0] >= 12), 32'd1);
            checkOutput("issue_spacing12", 32'(issueLog[2] - issueLog[1] >= 12), 32'd1);
            checkOutput("enable_gap1", 32'(gapLog[1] >= 2), 32'd1);
            checkOutput("enable_gap2", 32'(gapLog[2] >= 2), 32'd1);
        end
        @(posedge clock);
        #2;

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        prodLog.delete();
        applyStimulus(4'sd1, 4'sd2);
        applyStimulus(4'sd2, 4'sd3);
        applyStimulus(-4'sd1, 4'sd4);
        applyStimulus(4'sd3, -4'sd3);
        applyStimulus(-4'sd2, -4'sd5);
        repeat (20) @(negedge clock);
        heldRes = bus.out_res;
        checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("bp_out_res", 32'(bus.out_res), 32'h02);
        checkOutput("bp_fifo_full", 32'(fifo_count), 32'd4);
        checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("bp_no_second_issue", 32'(busy), 32'd0);
        repeat (5) @(negedge clock);
        checkOutput("bp_res_stable", 32'(bus.out_res), 32'(heldRes));
        @(posedge clock);
        #2;
        bus.out_ready = 1'b1;
        waitProducts(5, 300);
        if (prodLog.size() == 5) begin
            checkOutput("bp_drain0", 32'(prodLog[0]), 32'h02);
            checkOutput("bp_drain1", 32'(prodLog[1]), 32'h06);
            checkOutput("bp_drain2", 32'(prodLog[2]), 32'hFC);
            checkOutput("bp_drain3", 32'(prodLog[3]), 32'hF7);
            checkOutput("bp_drain4", 32'(prodLog[4]), 32'h0A);
        end
        @(posedge clock);
        #2;

        $display("[TB] push and pop together");
        bus.out_ready = 1'b0;
        prodLog.delete();
        applyStimulus(4'sd1, 4'sd3);
        applyStimulus(4'sd2, 4'sd2);
        applyStimulus(4'sd3, 4'sd1);
        waitValid(60);
        checkOutput("pp_count_before", 32'(fifo_count), 32'd2);
        @(posedge clock);
        #2;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #2;
        bus.in_mpd   = 4'sd4;
        bus.in_mpr   = 4'sd1;
        bus.in_valid = 1'b1;
        @(negedge clock);
        checkOutput("pp_idle_before_issue", 32'(busy), 32'd0);
        @(posedge clock);
        #2;
        bus.in_valid = 1'b0;
        @(negedge clock);
        checkOutput("pp_count_after", 32'(fifo_count), 32'd2);
        checkOutput("pp_issued", 32'(busy), 32'd1);
        waitProducts(4, 200);
        if (prodLog.size() == 4) begin
            checkOutput("pp_res0", 32'(prodLog[0]), 32'h03);
            checkOutput("pp_res1", 32'(prodLog[1]), 32'h04);
            checkOutput("pp_res2", 32'(prodLog[2]), 32'h03);
            checkOutput("pp_res3", 32'(prodLog[3]), 32'h04);
        end
        @(posedge clock);
        #2;

        $display("[TB] nine sequential operations");
        prodLog.delete();
        for (int i = 0; i < 9; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            expQ.push_back(prod(ra, rb));
            applyStimulus(ra, rb);
        end
        waitProducts(9, 400);
        if (prodLog.size() == 9) begin
            for (int i = 0; i < 9; i++) checkOutput("seq_res", 32'(prodLog[i]), 32'(expQ[i]));
        end
        @(posedge clock);
        #2;

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.in_mpd    = W'($urandom);
            bus.in_mpr    = W'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clock);
            #2;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((bus.out_valid || busy || fifo_count != '0) && n < 400) begin
            @(posedge clock);
            #2;
            n++;
        end
        checkOutput("random_drained", 32'(bus.out_valid || busy || fifo_count != '0), 32'd0);

        $display("[TB] reset during issue");
        applyStimulus(4'sd1, 4'sd1);
        applyStimulus(4'sd1, 4'sd2);
        n = 0;
        @(negedge clock);
        while (!(bus.mul_enable && cyc - lastIssueCyc == 4) && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("mid_issue_reached", 32'(bus.mul_enable && cyc - lastIssueCyc == 4), 32'd1);
        checkOutput("mid_issue_fifo_nonempty", 32'(fifo_count), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_mul_enable", 32'(bus.mul_enable), 32'd0);
        checkOutput("async_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        applyStimulus(4'sd2, 4'sd3);
        waitValid(40);
        checkOutput("after_reset_res", 32'(bus.out_res), 32'h06);
        checkOutput("after_reset_latency", 32'(validRiseCyc - lastIssueCyc), 32'd11);
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
